pc_redirect_unit: RTL and testbench

- Owns the program counter and consumes the taken/not-taken decision and target produced by the EX-stage branch comparator.
- Steers instruction fetch: sequential PC+4, holds on stall or instruction-memory busy, redirects on a taken branch or jump.
- Generates IF/ID and ID/EX flush pulses for wrong-path instructions.
- Sits between the branch select logic and the IF stage / instruction memory interface.

---
 rtl/pc_redirect_unit.sv | 141 ++++++++++++++
 tb/tb_pc_redirect_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: owns the fetch PC and steers instruction fetch.
// The PC advances sequentially, holds on a stall or a busy instruction
// memory, and redirects on an EX-stage taken branch or jump. The unit
// also drives the IF/ID and ID/EX flush strobes that squash wrong-path
// instructions.
//
// Optional build macro: PC_REDIRECT_STATS_EN adds the redirect_count and
// hold_cycles statistics outputs.
//
// state | meaning
// ------+----------------------------------------------------------------
// FETCH | normal fetch: sequential, hold on stall/busy, immediate redirect
// HOLD  | aligned redirect arrived while imem busy; target parked until
//       | the instruction memory is ready again
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        stall,
  input  logic        imem_busy,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        imem_read,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        misalign_fault
`ifdef PC_REDIRECT_STATS_EN
  ,
  output logic [31:0] redirect_count,
  output logic [31:0] hold_cycles
`endif
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      state, next_state;
  logic [31:0] pend_target, pend_next;
  logic [31:0] pc_next;
  logic        fault_next;
  logic        hold_entry, hold_entry_next;
  logic        redirect_fire;
  logic        target_misaligned;

  assign pc_plus4          = pc + STEP;
  assign target_misaligned = (branch_target[1:0] != 2'b00);

  // State, PC and registered strobes; imem_read doubles as the
  // "out of reset" flag so the first edge after release only starts fetch.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state          <= FETCH;
      pc             <= RESET_PC;
      pend_target    <= 32'h0000_0000;
      imem_read      <= 1'b0;
      misalign_fault <= 1'b0;
      hold_entry     <= 1'b0;
    end else begin
      state          <= next_state;
      pc             <= pc_next;
      pend_target    <= pend_next;
      imem_read      <= 1'b1;
      misalign_fault <= fault_next;
      hold_entry     <= hold_entry_next;
    end
  end

  // Next-state, next-PC and combinational flush decode.
  always_comb begin
    next_state      = state;
    pc_next         = pc;
    pend_next       = pend_target;
    fault_next      = 1'b0;
    hold_entry_next = 1'b0;
    redirect_fire   = 1'b0;
    if_id_flush     = 1'b0;
    id_ex_flush     = 1'b0;
    if (imem_read) begin
      case (state)
        FETCH: begin
          if (branch_taken) begin
            if (target_misaligned) begin
              // Bad target: keep fetching from the current PC, report only.
              fault_next = 1'b1;
            end else begin
              if_id_flush = 1'b1;
              id_ex_flush = 1'b1;
              if (!imem_busy) begin
                pc_next       = branch_target;
                redirect_fire = 1'b1;
              end else begin
                pend_next       = branch_target;
                next_state      = HOLD;
                hold_entry_next = 1'b1;
              end
            end
          end else if (!(stall || imem_busy)) begin
            pc_next = pc_plus4;
          end
        end
        HOLD: begin
          // Branch inputs are ignored here; the parked target wins.
          if_id_flush = 1'b1;
          id_ex_flush = hold_entry;
          if (!imem_busy) begin
            pc_next       = pend_target;
            next_state    = FETCH;
            redirect_fire = 1'b1;
          end
        end
        default: begin
          next_state = FETCH;
        end
      endcase
    end
  end

`ifdef PC_REDIRECT_STATS_EN
  // Saturating counters of completed redirects and cycles parked in HOLD.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      redirect_count <= 32'h0000_0000;
      hold_cycles    <= 32'h0000_0000;
    end else begin
      if (redirect_fire && (redirect_count != 32'hFFFF_FFFF))
        redirect_count <= redirect_count + 32'd1;
      if (imem_read && (state == HOLD) && (hold_cycles != 32'hFFFF_FFFF))
        hold_cycles <= hold_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
module tb_pc_redirect_unit;

  logic        CLK;
  logic        RESET;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        stall;
  logic        imem_busy;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        imem_read;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        misalign_fault;
`ifdef PC_REDIRECT_STATS_EN
  logic [31:0] redirect_count;
  logic [31:0] hold_cycles;
`endif

  int errors = 0;
  int checks = 0;

  pc_redirect_unit dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .stall          (stall),
    .imem_busy      (imem_busy),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .imem_read      (imem_read),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .misalign_fault (misalign_fault)
`ifdef PC_REDIRECT_STATS_EN
    ,
    .redirect_count (redirect_count),
    .hold_cycles    (hold_cycles)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    stall         = 1'b0;
    imem_busy     = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    RESET = 1'b0;
    repeat (3) step();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
    checks++; if (imem_read !== 1'b0) begin errors++; $display("FAIL reset_imem_read got=%b exp=0", imem_read); end
    checks++; if ({if_id_flush, id_ex_flush, misalign_fault} !== 3'b000) begin errors++; $display("FAIL reset_strobes got=%b exp=000", {if_id_flush, id_ex_flush, misalign_fault}); end
    RESET = 1'b1;
  endtask

  task automatic test_free_run();
    logic [31:0] exp_seq [4];
    exp_seq[0] = 32'h0; exp_seq[1] = 32'h4; exp_seq[2] = 32'h8; exp_seq[3] = 32'hC;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL release_pc got=%h exp=%h", pc, 32'h0); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (pc !== exp_seq[i]) begin errors++; $display("FAIL free_run_pc[%0d] got=%h exp=%h", i, pc, exp_seq[i]); end
      checks++; if (imem_read !== 1'b1) begin errors++; $display("FAIL free_run_imem_read[%0d] got=%b exp=1", i, imem_read); end
    end
    checks++; if (pc_plus4 !== 32'h10) begin errors++; $display("FAIL pc_plus4 got=%h exp=%h", pc_plus4, 32'h10); end
    step();
    checks++; if (pc !== 32'h10) begin errors++; $display("FAIL free_run_pc_10 got=%h exp=%h", pc, 32'h10); end
  endtask

  task automatic test_branch();
    branch_taken = 1'b1; branch_target = 32'h100;
    #1;
    checks++; if ({if_id_flush, id_ex_flush} !== 2'b11) begin errors++; $display("FAIL branch_flush got=%b exp=11", {if_id_flush, id_ex_flush}); end
    step();
    idle_inputs();
    #1;
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL branch_pc got=%h exp=%h", pc, 32'h100); end
    checks++; if ({if_id_flush, id_ex_flush} !== 2'b00) begin errors++; $display("FAIL branch_flush_after got=%b exp=00", {if_id_flush, id_ex_flush}); end
    step();
    checks++; if (pc !== 32'h104) begin errors++; $display("FAIL branch_seq got=%h exp=%h", pc, 32'h104); end
  endtask

  task automatic test_branch_busy();
    // Cycle A: redirect request while memory busy.
    branch_taken = 1'b1; branch_target = 32'h200; imem_busy = 1'b1;
    #1;
    checks++; if ({if_id_flush, id_ex_flush} !== 2'b11) begin errors++; $display("FAIL busy_req_flush got=%b exp=11", {if_id_flush, id_ex_flush}); end
    step();
    // Cycle B: first HOLD cycle.
    branch_taken = 1'b0;
    #1;
    checks++; if ({if_id_flush, id_ex_flush} !== 2'b11) begin errors++; $display("FAIL hold_entry_flush got=%b exp=11", {if_id_flush, id_ex_flush}); end
    checks++; if (pc !== 32'h104) begin errors++; $display("FAIL hold_pc_b got=%h exp=%h", pc, 32'h104); end
    step();
    // Cycle C: still busy, a stray taken branch must be ignored.
    branch_taken = 1'b1; branch_target = 32'h300;
    #1;
    checks++; if ({if_id_flush, id_ex_flush} !== 2'b10) begin errors++; $display("FAIL hold_mid_flush got=%b exp=10", {if_id_flush, id_ex_flush}); end
    checks++; if (imem_read !== 1'b1) begin errors++; $display("FAIL hold_imem_read got=%b exp=1", imem_read); end
    step();
    // Cycle D: memory ready, last HOLD cycle.
    branch_taken = 1'b0; imem_busy = 1'b0;
    #1;
    checks++; if ({if_id_flush, id_ex_flush} !== 2'b10) begin errors++; $display("FAIL hold_exit_flush got=%b exp=10", {if_id_flush, id_ex_flush}); end
    checks++; if (pc !== 32'h104) begin errors++; $display("FAIL hold_pc_d got=%h exp=%h", pc, 32'h104); end
    step();
    checks++; if (pc !== 32'h200) begin errors++; $display("FAIL hold_redirect_pc got=%h exp=%h", pc, 32'h200); end
    checks++; if ({if_id_flush, id_ex_flush} !== 2'b00) begin errors++; $display("FAIL hold_done_flush got=%b exp=00", {if_id_flush, id_ex_flush}); end
    step();
    checks++; if (pc !== 32'h204) begin errors++; $display("FAIL hold_after_seq got=%h exp=%h", pc, 32'h204); end
  endtask

  task automatic test_stall_vs_branch();
    branch_taken = 1'b1; branch_target = 32'h40;
    step();
    branch_taken = 1'b0; stall = 1'b1;
    step();
    step();
    checks++; if (pc !== 32'h40) begin errors++; $display("FAIL stall_hold_pc got=%h exp=%h", pc, 32'h40); end
    checks++; if (imem_read !== 1'b1) begin errors++; $display("FAIL stall_imem_read got=%b exp=1", imem_read); end
    branch_taken = 1'b1; branch_target = 32'h80;
    #1;
    checks++; if ({if_id_flush, id_ex_flush} !== 2'b11) begin errors++; $display("FAIL stall_branch_flush got=%b exp=11", {if_id_flush, id_ex_flush}); end
    step();
    idle_inputs();
    checks++; if (pc !== 32'h80) begin errors++; $display("FAIL stall_branch_pc got=%h exp=%h", pc, 32'h80); end
  endtask

  task automatic test_misalign();
    branch_taken = 1'b1; branch_target = 32'h102;
    #1;
    checks++; if ({if_id_flush, id_ex_flush} !== 2'b00) begin errors++; $display("FAIL misalign_flush got=%b exp=00", {if_id_flush, id_ex_flush}); end
    checks++; if (misalign_fault !== 1'b0) begin errors++; $display("FAIL misalign_early got=%b exp=0", misalign_fault); end
    step();
    idle_inputs();
    checks++; if (pc !== 32'h80) begin errors++; $display("FAIL misalign_pc got=%h exp=%h", pc, 32'h80); end
    checks++; if (misalign_fault !== 1'b1) begin errors++; $display("FAIL misalign_pulse got=%b exp=1", misalign_fault); end
    step();
    checks++; if (misalign_fault !== 1'b0) begin errors++; $display("FAIL misalign_clear got=%b exp=0", misalign_fault); end
    checks++; if (pc !== 32'h84) begin errors++; $display("FAIL misalign_resume got=%h exp=%h", pc, 32'h84); end
  endtask

  task automatic test_wrap();
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    step();
    idle_inputs();
    checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_load got=%h exp=%h", pc, 32'hFFFF_FFFC); end
    checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_plus4 got=%h exp=%h", pc_plus4, 32'h0); end
    step();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc got=%h exp=%h", pc, 32'h0); end
  endtask

  task automatic test_reset_mid_hold();
    step();
    step();
    branch_taken = 1'b1; branch_target = 32'h500; imem_busy = 1'b1;
    step();
    branch_taken = 1'b0;
    #1;
    checks++; if (if_id_flush !== 1'b1) begin errors++; $display("FAIL pre_reset_hold got=%b exp=1", if_id_flush); end
    #1;
    RESET = 1'b0;
    #1;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL async_reset_pc got=%h exp=%h", pc, 32'h0); end
    checks++; if ({imem_read, if_id_flush, id_ex_flush} !== 3'b000) begin errors++; $display("FAIL async_reset_strobes got=%b exp=000", {imem_read, if_id_flush, id_ex_flush}); end
    step();
    RESET = 1'b1; imem_busy = 1'b0;
    step();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rerelease_pc got=%h exp=%h", pc, 32'h0); end
    checks++; if (imem_read !== 1'b1) begin errors++; $display("FAIL rerelease_imem_read got=%b exp=1", imem_read); end
    step();
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL pending_lost got=%h exp=%h", pc, 32'h4); end
  endtask

  initial begin
    RESET = 1'b0;
    idle_inputs();
    #1;
    test_reset();
    test_free_run();
    test_branch();
    test_branch_busy();
    test_stall_vs_branch();
    test_misalign();
    test_wrap();
    test_reset_mid_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
